// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_e      : controller FSM states
//   DefaultWidth : default operand/result width
//   MinWidth / MaxWidth, width_ok() : legal WIDTH range and its check
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned MinWidth     = 2;
  localparam int unsigned MaxWidth     = 64;

  function automatic bit width_ok(input int unsigned w);
    return (w >= MinWidth) && (w <= MaxWidth);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell, purely combinational.
//   abc_i  : packed inputs, bit0 = a, bit1 = b, bit2 = carry-in
//   sum_o  : a ^ b ^ carry-in
//   cout_o : majority(a, b, carry-in)
module full_adder (
  input  logic [2:0] abc_i,
  output logic       sum_o,
  output logic       cout_o
);

  assign sum_o  = ^abc_i;
  assign cout_o = (abc_i[0] & abc_i[1]) | (abc_i[0] & abc_i[2]) | (abc_i[1] & abc_i[2]);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one full_adder cell over WIDTH cycles
// to produce {cout_o, sum_o} = a_i + b_i + cin_i.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   in_valid_i / in_ready_o : operand handshake (ready only in idle)
//   a_i, b_i, cin_i         : operands, captured on the input handshake
//   out_valid_o / out_ready_i : result handshake (valid only in done)
//   sum_o, cout_o           : result, held while out_valid_o is high
//   ovf_o                   : signed overflow, present only with SERIAL_ADD_OVF_EN
//   busy_o                  : operation in progress (run or done)
// Build option: define SERIAL_ADD_OVF_EN to add the ovf_o output.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf_o,
`endif
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : gen_width_check
    $error("serial_add_ctrl: WIDTH out of range 2..64");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .abc_i  ({carry_q, b_sh_q[0], a_sh_q[0]}),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;
`endif

  // Handshake flags are registered alongside the state so that every output
  // comes straight from a flop; in_ready_q stays low for the reset cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i && in_ready_q) begin
            a_sh_q     <= a_i;
            b_sh_q     <= b_i;
            carry_q    <= cin_i;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StRun;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        StRun: begin
          // LSB-first: sum bits enter at the MSB and drift down to bit 0.
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= {fa_sum, sum_sh_q[WIDTH-1:1]};
          carry_q  <= fa_cout;
          if (cnt_q == LastBit) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
`ifdef SERIAL_ADD_OVF_EN
            // Carry into the MSB xor carry out of the MSB.
            ovf_q       <= carry_q ^ fa_cout;
`endif
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign sum_o       = sum_sh_q;
  assign cout_o      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a WIDTH=8 instance for directed
// cases (latency, backpressure, mid-run reset) and a WIDTH=16 instance for
// back-to-back random traffic. Expected results are queued at the input
// handshake and compared at the output handshake.
module tb_serial_add_ctrl;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // WIDTH=8 instance signals
  logic       v8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, cout8, busy8, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       ovf8;
  // WIDTH=16 instance signals
  logic        v16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1, cout16, busy16;
  logic        cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        ovf16;

`ifndef SERIAL_ADD_OVF_EN
  assign ovf8  = 1'b0;
  assign ovf16 = 1'b0;
`endif

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (v8),
    .in_ready_o  (in_ready8),
    .a_i         (a8),
    .b_i         (b8),
    .cin_i       (cin8),
    .out_valid_o (out_valid8),
    .out_ready_i (out_ready8),
    .sum_o       (sum8),
    .cout_o      (cout8),
`ifdef SERIAL_ADD_OVF_EN
    .ovf_o       (ovf8),
`endif
    .busy_o      (busy8)
  );

  serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (v16),
    .in_ready_o  (in_ready16),
    .a_i         (a16),
    .b_i         (b16),
    .cin_i       (cin16),
    .out_valid_o (out_valid16),
    .out_ready_i (out_ready16),
    .sum_o       (sum16),
    .cout_o      (cout16),
`ifdef SERIAL_ADD_OVF_EN
    .ovf_o       (ovf16),
`endif
    .busy_o      (busy16)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: full-precision add, signed overflow from operand/result signs.
  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] r;
    exp_t e;
    r = {1'b0, a} + {1'b0, b} + {8'd0, c};
    e.sum  = {8'd0, r[7:0]};
    e.cout = r[8];
    e.ovf  = (a[7] == b[7]) && (r[7] != a[7]);
    return e;
  endfunction

  function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] r;
    exp_t e;
    r = {1'b0, a} + {1'b0, b} + {16'd0, c};
    e.sum  = r[15:0];
    e.cout = r[16];
    e.ovf  = (a[15] == b[15]) && (r[15] != a[15]);
    return e;
  endfunction

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   t8 = 0, t16 = 0;
  logic ov8_prev = 1'b0;
  logic have16 = 1'b0;

  // Monitors sample on the falling edge, midway between active edges.
  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      ov8_prev = 1'b0;
    end else begin
      if (v8 && in_ready8) begin
        q8.push_back(model8(a8, b8, cin8));
        t8 = cyc;
      end
      if (out_valid8 && !ov8_prev) check_eq("latency8", 64'(cyc - t8), 64'd9);
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) begin
          check_eq("spurious8", {63'd0, out_valid8}, 64'd0);
        end else begin
          e8 = q8.pop_front();
          check_eq("sum8", {56'd0, sum8}, {48'd0, e8.sum});
          check_eq("cout8", {63'd0, cout8}, {63'd0, e8.cout});
`ifdef SERIAL_ADD_OVF_EN
          check_eq("ovf8", {63'd0, ovf8}, {63'd0, e8.ovf});
`endif
        end
      end
      ov8_prev = out_valid8;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      have16 = 1'b0;
    end else begin
      if (v16 && in_ready16) begin
        q16.push_back(model16(a16, b16, cin16));
        if (have16) check_eq("interval16", 64'(cyc - t16), 64'd18);
        t16 = cyc;
        have16 = 1'b1;
      end
      if (out_valid16 && out_ready16) begin
        if (q16.size() == 0) begin
          check_eq("spurious16", {63'd0, out_valid16}, 64'd0);
        end else begin
          e16 = q16.pop_front();
          check_eq("sum16", {48'd0, sum16}, {48'd0, e16.sum});
          check_eq("cout16", {63'd0, cout16}, {63'd0, e16.cout});
`ifdef SERIAL_ADD_OVF_EN
          check_eq("ovf16", {63'd0, ovf16}, {63'd0, e16.ovf});
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; returns in the first RUN cycle.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c; v8 = 1'b1;
    for (int k = 0; k < 40 && !in_ready8; k++) tick();
    if (!in_ready8) check_eq("ready8_timeout", {63'd0, in_ready8}, 64'd1);
    tick();
    v8 = 1'b0;
  endtask

  task automatic drain8();
    for (int k = 0; k < 60 && (q8.size() != 0 || out_valid8); k++) tick();
    check_eq("drain8", 64'(q8.size()), 64'd0);
  endtask

  initial begin
    exp_t bp;
    // Reset state, sampled while reset is still asserted.
    repeat (3) tick();
    check_eq("rst_in_ready", {63'd0, in_ready8}, 64'd0);
    check_eq("rst_out_valid", {63'd0, out_valid8}, 64'd0);
    check_eq("rst_busy", {63'd0, busy8}, 64'd0);
    check_eq("rst_sum", {56'd0, sum8}, 64'd0);
    check_eq("rst_cout", {63'd0, cout8}, 64'd0);
    check_eq("rst_ovf", {63'd0, ovf8}, 64'd0);
    rst = 1'b0;
    tick();
    check_eq("idle_in_ready", {63'd0, in_ready8}, 64'd1);

    // Directed adds through the scoreboard.
    run8(8'h3C, 8'h05, 1'b0);
    drain8();
    run8(8'hFF, 8'h01, 1'b1);
    drain8();
    run8(8'h7F, 8'h01, 1'b0);
    drain8();

    // Backpressure: result must hold and new operands must be ignored.
    out_ready8 = 1'b0;
    bp = model8(8'hA5, 8'h5A, 1'b1);
    run8(8'hA5, 8'h5A, 1'b1);
    for (int k = 0; k < 20 && !out_valid8; k++) tick();
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_sum", {56'd0, sum8}, {48'd0, bp.sum});
      check_eq("bp_cout", {63'd0, cout8}, {63'd0, bp.cout});
      check_eq("bp_valid", {63'd0, out_valid8}, 64'd1);
      check_eq("bp_in_ready", {63'd0, in_ready8}, 64'd0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      v8 = k[0];
      tick();
    end
    v8 = 1'b0;
    out_ready8 = 1'b1;
    tick();
    check_eq("post_out_in_ready", {63'd0, in_ready8}, 64'd1);
    check_eq("post_out_valid", {63'd0, out_valid8}, 64'd0);
    drain8();

    // Reset in the 4th RUN cycle discards the operation.
    run8(8'h33, 8'h44, 1'b0);
    repeat (3) tick();
    check_eq("run_busy", {63'd0, busy8}, 64'd1);
    check_eq("run_in_ready", {63'd0, in_ready8}, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_valid", {63'd0, out_valid8}, 64'd0);
    check_eq("midrst_busy", {63'd0, busy8}, 64'd0);
    check_eq("midrst_sum", {56'd0, sum8}, 64'd0);
    check_eq("midrst_cout", {63'd0, cout8}, 64'd0);
    repeat (12) tick();
    run8(8'h10, 8'h20, 1'b0);
    drain8();

    // Back-to-back random traffic on the 16-bit instance.
    for (int i = 0; i < 100; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      cin16 = 1'($urandom);
      v16 = 1'b1;
      for (int k = 0; k < 40 && !in_ready16; k++) tick();
      if (!in_ready16) check_eq("ready16_timeout", {63'd0, in_ready16}, 64'd1);
      tick();
    end
    v16 = 1'b0;
    for (int k = 0; k < 60 && (q16.size() != 0 || out_valid16); k++) tick();
    check_eq("drain16", 64'(q16.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
